// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed seven-segment scan controller
//
// Purpose:
//   Scans DIGITS seven-segment digits from a single clock. A hex value plus
//   per-digit decimal points are double-buffered (pending -> shadow), so a
//   displayed frame never mixes old and new data. Adds a per-slot anode-off
//   guard time against ghosting, leading-zero blanking and per-digit blinking.
//
// Configuration macro:
//   SEG_SCAN_BLINK_EN - when defined, the blink counter, blink_phase and
//                       blink masking are built. When undefined, blink_mask is
//                       accepted but ignored.
//
// Parameters:
//   DIGITS       number of digits scanned (2..8)
//   REFRESH_DIV  clock cycles per digit slot (>= GUARD+2)
//   GUARD        cycles at the start of each slot with all anodes off
//   BLINK_FRAMES full frames per blink half-period (>= 1)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   value        in   4*DIGITS hex nibbles, nibble i -> digit i (0 = rightmost)
//   dp_in        in   decimal point request per digit, active-high
//   load         in   one-cycle strobe capturing value/dp_in
//   lzb          in   leading-zero blanking enable, sampled live
//   blink_mask   in   digits that blink, active-high
//   seg_atog     out  segments a..g on bits 0..6, active-low
//   seg_dp       out  decimal point, active-low
//   seg_an       out  anode enables, active-low
//   frame_start  out  one-cycle pulse as the outputs enter slot 0

module seg_scan_display #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lzb,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg_atog,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     seg_an,
  output logic                  frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW-1:0] GUARD_C   = PW'(GUARD);
  localparam bit            HAS_GUARD = (GUARD > 0);

  // Scan position
  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          frame_end;

  // Double buffer
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_valid;
  logic [4*DIGITS-1:0] shad_val;
  logic [DIGITS-1:0]   shad_dp;

  // Per-digit blanking and current-slot selection
  logic [DIGITS-1:0] lz_blank;
  logic [DIGITS-1:0] blink_blank;
  logic [DIGITS-1:0] an_onehot;
  logic              upper_zero;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_lz;
  logic              cur_blink;
  logic              in_guard;

  // Next registered outputs
  logic [6:0]        seg_atog_d;
  logic              seg_dp_d;
  logic [DIGITS-1:0] seg_an_d;
  logic              frame_start_d;

  assign slot_end  = (pcnt == PCNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Active-low glyphs, bit0 = a ... bit6 = g
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Prescaler and digit index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      if (slot_end) begin
        pcnt <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // Pending/shadow buffers. A load landing on the frame boundary bypasses the
  // pending stage so it is shown in the very next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      shad_val   <= '0;
      shad_dp    <= '0;
    end else if (load && frame_end) begin
      shad_val   <= value;
      shad_dp    <= dp_in;
      pend_valid <= 1'b0;
    end else begin
      if (frame_end && pend_valid) begin
        shad_val   <= pend_val;
        shad_dp    <= pend_dp;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Counts frame boundaries; phase flips every BLINK_FRAMES of them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign blink_blank = blink_phase ? blink_mask : '0;
`else
  logic unused_blink_mask;

  assign unused_blink_mask = ^blink_mask;
  assign blink_blank       = '0;
`endif

  // Leading-zero blanking: walk from the top digit down while nibbles stay
  // zero. Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (shad_val[4*i +: 4] == 4'h0);
      lz_blank[i] = lzb && upper_zero;
    end
  end

  // Select the data belonging to the digit currently being scanned
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    cur_blink = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib      = shad_val[4*i +: 4];
        cur_dp       = shad_dp[i];
        cur_lz       = lz_blank[i];
        cur_blink    = blink_blank[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  // Output decode. Blanked digits keep their anode driven so every slot
  // carries the same duty cycle and lit digits keep uniform brightness.
  always_comb begin
    in_guard      = HAS_GUARD && (pcnt < GUARD_C);
    seg_atog_d    = 7'h7F;
    seg_dp_d      = 1'b1;
    seg_an_d      = '1;
    frame_start_d = (pcnt == '0) && (idx == '0);
    if (!in_guard) begin
      seg_an_d = ~an_onehot;
      if (!cur_blink) begin
        seg_dp_d = ~cur_dp;
        if (!cur_lz) begin
          seg_atog_d = hex_glyph(cur_nib);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_atog    <= 7'h7F;
      seg_dp      <= 1'b1;
      seg_an      <= '1;
      frame_start <= 1'b0;
    end else begin
      seg_atog    <= seg_atog_d;
      seg_dp      <= seg_dp_d;
      seg_an      <= seg_an_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - directed self-checking bench for seg_scan_display

module tb_seg_scan_display;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg_atog;
  logic        seg_dp;
  logic [3:0]  seg_an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int fnum   = 0;

`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  seg_scan_display #(
    .DIGITS      (4),
    .REFRESH_DIV (8),
    .GUARD       (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .lzb        (lzb),
    .blink_mask (blink_mask),
    .seg_atog   (seg_atog),
    .seg_dp     (seg_dp),
    .seg_an     (seg_an),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full 32-cycle frame, checked every cycle. Called right after the
  // negedge preceding output cycle 0. segs = {d3,d2,d1,d0} glyphs, dpn =
  // expected active-low dp per digit. la1/la2 = cycle after which a load is
  // driven (-1 for none).
  task automatic run_frame(input logic [27:0] segs, input logic [3:0] dpn,
                           input int la1, input logic [15:0] lv1, input logic [3:0] ld1,
                           input int la2, input logic [15:0] lv2);
    logic [6:0]  eseg;
    logic        edp;
    logic [3:0]  ean;
    logic [12:0] expv;
    int s, p;
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      s = c / 8;
      p = c % 8;
      if (p < 2) begin
        ean  = 4'hF;
        eseg = 7'h7F;
        edp  = 1'b1;
      end else begin
        ean  = ~(4'b0001 << s);
        eseg = segs[s*7 +: 7];
        edp  = dpn[s];
        if (BLINK_ON && ((fnum % 4) >= 2) && blink_mask[s]) begin
          eseg = 7'h7F;
          edp  = 1'b1;
        end
      end
      expv = {(c == 0), ean, eseg, edp};
      chk($sformatf("f%0d_c%0d", fnum, c), {19'b0, frame_start, seg_an, seg_atog, seg_dp},
          {19'b0, expv});
      load = 1'b0;
      if (c == la1) begin
        value = lv1;
        dp_in = ld1;
        load  = 1'b1;
      end
      if (c == la2) begin
        value = lv2;
        load  = 1'b1;
      end
    end
    fnum++;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_seg", {25'b0, seg_atog}, 32'h7F);
    chk("rst_dp", {31'b0, seg_dp}, 32'h1);
    chk("rst_an", {28'b0, seg_an}, 32'hF);
    chk("rst_fs", {31'b0, frame_start}, 32'h0);
    reset = 1'b1;

    // F0: cleared shadow shows 0000; load 1208 mid-frame
    run_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 5, 16'h1208, 4'h0, -1, 16'h0);
    lzb = 1'b1;
    // F1: 1208; load 0050 with dp on digit 3
    run_frame({7'h79, 7'h24, 7'h40, 7'h00}, 4'hF, 10, 16'h0050, 4'b1000, -1, 16'h0);
    // F2: 0050 with leading-zero blanking; load ABCD exactly on the boundary
    run_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0111, 30, 16'hABCD, 4'h0, -1, 16'h0);
    // F3: ABCD with no extra frame delay; two mid-frame loads
    run_frame({7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 5, 16'h1111, 4'h0, 12, 16'h2222);
    blink_mask = 4'b0001;
    // F4..F7: last load wins; digit 0 blinks in F6/F7 when built in
    run_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);
    run_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);
    run_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);
    run_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);

    // Mid-slot-2 asynchronous reset
    for (int c = 0; c < 20; c++) @(negedge clock);
    chk("pre_rst_an", {28'b0, seg_an}, 32'hB);
    chk("pre_rst_seg", {25'b0, seg_atog}, 32'h24);
    #2 reset = 1'b0;
    #1;
    chk("arst_seg", {25'b0, seg_atog}, 32'h7F);
    chk("arst_dp", {31'b0, seg_dp}, 32'h1);
    chk("arst_an", {28'b0, seg_an}, 32'hF);
    chk("arst_fs", {31'b0, frame_start}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    chk("arst_hold_an", {28'b0, seg_an}, 32'hF);
    reset = 1'b1;
    fnum  = 0;

    // Restart at slot 0 with cleared shadow; lzb=1 leaves only digit 0
    run_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);
    lzb = 1'b0;
    // lzb sampled live: all zeros now visible
    run_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, single-clock multiplexed seven-segment display controller that replaces the hand-built 4-digit scan logic in the board top level. It takes a DIGITS-nibble hex value plus per-digit decimal points, double-buffers them so a display frame never mixes old and new data, and time-multiplexes active-low segment/anode outputs. It adds ghost-suppression guard time, leading-zero blanking and per-digit blinking. It uses no derived clocks; refresh timing comes from an internal prescaler.

## Interface
- DIGITS, 4: number of digits scanned (2..8).
- REFRESH_DIV, 50000: clock cycles per digit slot (≥ GUARD+2).
- GUARD, 2: cycles at the start of each slot with all anodes off (0 allowed).
- BLINK_FRAMES, 250: full frames per blink half-period (≥1).

- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- value  input  4*DIGITS  hex digits; nibble i drives digit i (digit 0 = rightmost).
- dp_in  input  DIGITS  decimal point request per digit, active-high.
- load  input  1  one-cycle strobe: capture value/dp_in into pending buffer.
- lzb  input  1  leading-zero blanking enable (sampled live).
- blink_mask  input  DIGITS  digits that blink, active-high.
- seg_atog  output  7  segments, active-low; bit0=a … bit6=g.
- seg_dp  output  1  decimal point, active-low.
- seg_an  output  DIGITS  anode enables, active-low, one-hot-low when lit.
- frame_start  output  1  one-cycle pulse when slot 0 begins.

## Operation
- Prescaler pcnt counts 0..REFRESH_DIV-1, wraps; slot_end = (pcnt == REFRESH_DIV-1).
- Digit index idx advances on slot_end, DIGITS-1 wraps to 0; frame boundary = slot_end with idx==DIGITS-1.
- Buffers: pending (value, dp, pend_valid) and shadow (value, dp). load=1 writes pending, sets pend_valid.
- At frame boundary, if pend_valid: shadow ← pending, pend_valid ← 0. If load coincides with frame boundary, shadow takes the load data directly, pend_valid stays 0.
- Decode: standard hex glyphs 0-9, A, b, C, d, E, F (active-low: 0→7'h40, 1→7'h79, 8→7'h00, F→7'h0E).
- Leading-zero blank: digit i (i≥1) blank when lzb=1 and shadow nibbles i..DIGITS-1 all zero; digit 0 never LZ-blanked. A blanked digit's dp still shows if dp set.
- Blink: blink_phase toggles every BLINK_FRAMES frame boundaries; when blink_phase=1, digits in blink_mask fully blank (segments and dp off).
- Blank digit: seg_atog=7'h7F, seg_dp=1, anode still driven (uniform brightness).
- Guard: for pcnt < GUARD, seg_an all 1 and seg_atog/seg_dp all 1.

## Timing
- All outputs registered; output reflects idx/pcnt state one cycle later. Slot for digit k: anode k low for REFRESH_DIV-GUARD cycles per slot.
- frame_start high for the single cycle in which registered outputs enter slot 0 guard (or slot 0 drive if GUARD=0).
- Data captured by load visible from the first slot-0 after the next frame boundary: worst case DIGITS*REFRESH_DIV+1 cycles.
- Reset (any time, including mid-frame): pcnt=0, idx=0, shadow=0, dp=0, pend_valid=0, blink_phase=0, blink counter=0; seg_atog=7'h7F, seg_dp=1, seg_an all 1, frame_start=0. First frame_start appears one cycle after reset release.
- Back-to-back loads before a boundary: last one wins.

## Configuration
- SEG_SCAN_BLINK_EN defined: blink counter, blink_phase and masking compiled in as above.
- Not defined: no blink logic; blink_mask ignored (port kept); digits never blink-blanked.

## Test plan
- Reset then DIGITS=4, REFRESH_DIV=8, GUARD=2, load value=16'h1208 -> after next boundary, slots 0..3 show 7'h00, 7'h40, 7'h24, 7'h79 with seg_an 4'b1110/1101/1011/0111, each low 6 cycles, all-high 2 cycles.
- value=16'h0050, lzb=1, dp_in=4'b1000 -> digits 2 blank, digit 3 segments 7'h7F with seg_dp=0, digits 1,0 show 5 and 0.
- load asserted exactly on frame boundary with 16'hABCD -> next slot 0 shows d (7'h21) without an extra frame delay; pend_valid=0.
- Two loads mid-frame (16'h1111, then 16'h2222) -> frame continues old value; next frame shows all 2 (7'h24), never 1.
- BLINK_FRAMES=2, blink_mask=4'b0001, macro defined -> digit 0 blank for frames 2-3, lit 0-1, 4-5; macro undefined -> always lit.
- Assert reset low mid-slot 2 -> outputs 7'h7F/1/4'hF asynchronously; after release scan restarts at slot 0 showing 0 with shadow cleared.
